// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields in, datapath controls out
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic       regwrite;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  op, funct3, funct7b5, zero,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               immsrc, regwrite, alucontrol, illegal, state
    );
    modport slave (
        output op, funct3, funct7b5, zero,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               immsrc, regwrite, alucontrol, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    logic [3:0] state_q, nxt, s;
    logic       is_lw, is_sw, is_r, is_i, is_beq, is_jal, known;
    logic       pcupdate, branch, irw, rw, mw, rtsub;
    logic [1:0] aluop;
    logic [2:0] alu10;

    assign is_lw  = bus.op == 7'b0000011;
    assign is_sw  = bus.op == 7'b0100011;
    assign is_r   = bus.op == 7'b0110011;
    assign is_i   = bus.op == 7'b0010011;
    assign is_beq = bus.op == 7'b1100011;
    assign is_jal = bus.op == 7'b1101111;
    assign known  = is_lw | is_sw | is_r | is_i | is_beq | is_jal;

    // state register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        state_q <= reset ? RESET_STATE : nxt;
    end

    // next-state sequencing; unused encodings fall back to FETCH
    always_comb begin
        nxt = FETCH;
        case (state_q)
            FETCH:    nxt = DECODE;
            DECODE:   nxt = (is_lw | is_sw) ? MEMADR : is_r ? EXECUTER : is_i ? EXECUTEI :
                            is_beq ? BEQ : is_jal ? JAL : FETCH;
            MEMADR:   nxt = is_lw ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = MEMWB;
            EXECUTER: nxt = ALUWB;
            EXECUTEI: nxt = ALUWB;
            JAL:      nxt = ALUWB;
            default:  nxt = FETCH;
        endcase
    end

    // Moore decode; under reset the muxes show FETCH values and all enables drop
    always_comb begin
        s             = reset ? FETCH : state_q;
        irw           = 1'b0;
        rw            = 1'b0;
        mw            = 1'b0;
        pcupdate      = 1'b0;
        branch        = 1'b0;
        aluop         = 2'b00;
        bus.adrsrc    = 1'b0;
        bus.resultsrc = 2'b00;
        bus.alusrca   = 2'b00;
        bus.alusrcb   = 2'b00;
        case (s)
            FETCH: begin
                irw           = 1'b1;
                pcupdate      = 1'b1;
                bus.alusrcb   = 2'b10;
                bus.resultsrc = 2'b10;
            end
            DECODE: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
            end
            MEMADR: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
            end
            MEMREAD:  bus.adrsrc = 1'b1;
            MEMWB: begin
                bus.resultsrc = 2'b01;
                rw            = 1'b1;
            end
            MEMWRITE: begin
                bus.adrsrc = 1'b1;
                mw         = 1'b1;
            end
            EXECUTER: begin
                bus.alusrca = 2'b10;
                aluop       = 2'b10;
            end
            EXECUTEI: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                aluop       = 2'b10;
            end
            ALUWB:    rw = 1'b1;
            BEQ: begin
                bus.alusrca = 2'b10;
                aluop       = 2'b01;
                branch      = 1'b1;
            end
            JAL: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                pcupdate    = 1'b1;
            end
            default: ;
        endcase
    end

    // enables gated by reset; the branch term samples zero combinationally
    always_comb begin
        bus.state    = state_q;
        bus.irwrite  = irw & ~reset;
        bus.regwrite = rw & ~reset;
        bus.memwrite = mw & ~reset;
        bus.pcwrite  = ~reset & (pcupdate | (branch & bus.zero));
        bus.illegal  = ~reset & (state_q == DECODE) & ~known;
    end

    // ALU decoder; subtract only for R-type funct7b5 so addi never becomes sub
    always_comb begin
        rtsub          = bus.funct7b5 & bus.op[5];
        alu10          = bus.funct3 == 3'b000 ? {2'b00, rtsub} :
                         bus.funct3 == 3'b010 ? 3'b101 :
                         bus.funct3 == 3'b110 ? 3'b011 :
                         bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
        bus.alucontrol = aluop == 2'b00 ? 3'b000 : aluop == 2'b01 ? 3'b001 :
                         aluop == 2'b10 ? alu10 : 3'b000;
    end

    // immediate format depends on the opcode alone
    always_comb begin
        bus.immsrc = is_sw ? 2'b01 : is_beq ? 2'b10 : is_jal ? 2'b11 : 2'b00;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for the control FSM
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int passed = 0;
    int failed = 0;
    int total = 0;
    logic [20:0] sb[$];
    string tag;

    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [20:0] expv(input logic [3:0] st, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7,
                                         input logic z, input logic r);
        logic       pcw, ad, mw, irw, rw, il, ok;
        logic [1:0] rs, sa, sbv, im;
        logic [2:0] ac, arith;
        pcw = 0; ad = 0; mw = 0; irw = 0; rw = 0; il = 0;
        rs = 0; sa = 0; sbv = 0; ac = 0;
        ok = o inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};
        im = (o == 7'h23) ? 2'd1 : (o == 7'h63) ? 2'd2 : (o == 7'h6f) ? 2'd3 : 2'd0;
        case (f3)
            3'b000:  arith = (f7 && o == 7'h33) ? 3'b001 : 3'b000;
            3'b010:  arith = 3'b101;
            3'b110:  arith = 3'b011;
            3'b111:  arith = 3'b010;
            default: arith = 3'b000;
        endcase
        case (r ? 4'd0 : st)
            4'd0:  begin irw = 1; pcw = 1; sbv = 2'b10; rs = 2'b10; end
            4'd1:  begin sa = 2'b01; sbv = 2'b01; il = !ok; end
            4'd2:  begin sa = 2'b10; sbv = 2'b01; end
            4'd3:  ad = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin ad = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; ac = arith; end
            4'd7:  begin sa = 2'b10; sbv = 2'b01; ac = arith; end
            4'd8:  rw = 1;
            4'd9:  begin sa = 2'b10; ac = 3'b001; pcw = z; end
            4'd10: begin sa = 2'b01; sbv = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (r) begin pcw = 0; mw = 0; irw = 0; rw = 0; il = 0; end
        return {st, pcw, ad, mw, irw, rs, sa, sbv, im, rw, ac, il};
    endfunction

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, input string t);
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z; tag = t;
    endtask

    task automatic push_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z);
        logic [3:0] seq[$];
        case (o)
            7'h03:   seq = '{0, 1, 2, 3, 4};
            7'h23:   seq = '{0, 1, 2, 5};
            7'h33:   seq = '{0, 1, 6, 8};
            7'h13:   seq = '{0, 1, 7, 8};
            7'h63:   seq = '{0, 1, 9};
            7'h6f:   seq = '{0, 1, 10, 8};
            default: seq = '{0, 1};
        endcase
        foreach (seq[i]) sb.push_back(expv(seq[i], o, f3, f7, z, 1'b0));
    endtask

    task automatic drain();
        logic [20:0] e, obs;
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            obs = {bus.state, bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite,
                   bus.resultsrc, bus.alusrca, bus.alusrcb, bus.immsrc, bus.regwrite,
                   bus.alucontrol, bus.illegal};
            total++;
            assert (obs === e) passed++;
            else begin
                failed++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input string t);
        set_in(o, f3, f7, z, t);
        push_instr(o, f3, f7, z);
        drain();
    endtask

    initial begin
        set_in(7'h00, 3'b000, 1'b0, 1'b0, "reset");
        @(negedge clk);
        sb.push_back(expv(4'd0, 7'h00, 3'b000, 1'b0, 1'b0, 1'b1));
        sb.push_back(expv(4'd0, 7'h00, 3'b000, 1'b0, 1'b0, 1'b1));
        drain();
        reset = 1'b0;
        run(7'h03, 3'b010, 1'b0, 1'b0, "lw");
        run(7'h23, 3'b010, 1'b0, 1'b0, "sw");
        run(7'h33, 3'b000, 1'b1, 1'b0, "sub");
        run(7'h33, 3'b000, 1'b0, 1'b0, "add");
        run(7'h33, 3'b010, 1'b0, 1'b1, "slt");
        run(7'h33, 3'b110, 1'b0, 1'b0, "or");
        run(7'h33, 3'b111, 1'b0, 1'b0, "and");
        run(7'h33, 3'b001, 1'b0, 1'b0, "rsvd_f3");
        run(7'h13, 3'b000, 1'b1, 1'b0, "addi");
        run(7'h13, 3'b111, 1'b0, 1'b0, "andi");
        run(7'h63, 3'b000, 1'b0, 1'b1, "beq_taken");
        run(7'h63, 3'b000, 1'b0, 1'b0, "beq_not");
        run(7'h6f, 3'b000, 1'b0, 1'b0, "jal");
        run(7'h7f, 3'b000, 1'b0, 1'b0, "illegal");
        set_in(7'h03, 3'b010, 1'b0, 1'b0, "lw_abort");
        sb.push_back(expv(4'd0, 7'h03, 3'b010, 1'b0, 1'b0, 1'b0));
        sb.push_back(expv(4'd1, 7'h03, 3'b010, 1'b0, 1'b0, 1'b0));
        sb.push_back(expv(4'd2, 7'h03, 3'b010, 1'b0, 1'b0, 1'b0));
        drain();
        reset = 1'b1;
        sb.push_back(expv(4'd3, 7'h03, 3'b010, 1'b0, 1'b0, 1'b1));
        drain();
        reset = 1'b0;
        run(7'h03, 3'b010, 1'b0, 1'b0, "lw_after_abort");
        run(7'h23, 3'b010, 1'b0, 1'b1, "sw_zero");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
